shift_add_mul_ctrl: RTL and testbench

Multi-cycle unsigned shift-and-add multiplier controller. It sequences a single WIDTH-bit ripple-carry adder over WIDTH iterations to form a 2·WIDTH-bit product. It sits beside the execute stage as the MUL/UMULH resource. A start/busy/done handshake lets the pipeline stall while the unit runs.

---
 rtl/mul_pkg.sv | 15 +
 rtl/shift_add_mul_ctrl_adder.sv | 28 ++
 rtl/shift_add_mul_ctrl.sv | 88 ++++++++
 tb/tb_shift_add_mul_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and helpers for the shift-add multiplier
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    // Counter width able to hold values 0..n.
    function automatic int clog2p1(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/shift_add_mul_ctrl_adder.sv
// rtl/shift_add_mul_ctrl_adder.sv - structural WIDTH-bit ripple-carry adder
// Ports: i_a, i_b operands; o_sum sum; o_carry_out carry out of MSB;
//        o_overflow signed overflow (carry into MSB xor carry out).
module shift_add_mul_ctrl_adder #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry_out,
    output logic             o_overflow
);

    logic [WIDTH:0] w_carry;

    assign w_carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        logic w_p;
        assign w_p            = i_a[i] ^ i_b[i];
        assign o_sum[i]       = w_p ^ w_carry[i];
        assign w_carry[i + 1] = (i_a[i] & i_b[i]) | (w_p & w_carry[i]);
    end

    assign o_carry_out = w_carry[WIDTH];
    assign o_overflow  = w_carry[WIDTH] ^ w_carry[WIDTH - 1];

endmodule

// File: rtl/shift_add_mul_ctrl.sv
// rtl/shift_add_mul_ctrl.sv - multi-cycle unsigned shift-and-add multiplier controller
// Ports: clk, reset_n (async active-low); start, multiplicand, multiplier in;
//        busy (in RUN), done (one-cycle result pulse), product_hi/product_lo out.
module shift_add_mul_ctrl
    import mul_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CNT_W = clog2p1(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product_hi,
    output logic [WIDTH-1:0] product_lo
);

    mul_state_t       r_state;
    mul_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_addend;
    logic [WIDTH-1:0] w_sum;
    logic             w_carry_out;
    logic             w_last_iter;
    logic             w_accept;
    logic             w_adder_ovf_unused;

    // Only the LSB of the multiplier half decides whether A is added this step.
    assign w_addend    = r_lo[0] ? r_mcand : '0;
    assign w_last_iter = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_accept    = start && (r_state == IDLE || r_state == DONE);

    shift_add_mul_ctrl_adder #(
        .WIDTH(WIDTH)
    ) u_adder (
        .i_a         (r_hi),
        .i_b         (w_addend),
        .o_sum       (w_sum),
        .o_carry_out (w_carry_out),
        .o_overflow  (w_adder_ovf_unused)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (w_last_iter) w_state_nxt = DONE;
            DONE:    w_state_nxt = start ? RUN : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_mcand <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_mcand <= multiplicand;
                r_hi    <= '0;
                r_lo    <= multiplier;
                r_cnt   <= '0;
            end else if (r_state == RUN) begin
                // When nothing is added the sum equals hi and carry is 0, so
                // one shift covers both the add and no-add cases.
                {r_hi, r_lo} <= {w_carry_out, w_sum, r_lo[WIDTH-1:1]};
                r_cnt        <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign busy       = (r_state == RUN);
    assign done       = (r_state == DONE);
    assign product_hi = r_hi;
    assign product_lo = r_lo;

endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// tb/tb_shift_add_mul_ctrl.sv - self-checking bench for shift_add_mul_ctrl
module tb_shift_add_mul_ctrl;

    logic        clk;
    logic        reset_n;

    logic        s8, b8, d8;
    logic [7:0]  a8, m8, ph8, pl8;

    logic        s64, b64, d64;
    logic [63:0] a64, m64, ph64, pl64;

    int checks;
    int errors;

    shift_add_mul_ctrl #(.WIDTH(8)) dut8 (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (s8),
        .multiplicand (a8),
        .multiplier   (m8),
        .busy         (b8),
        .done         (d8),
        .product_hi   (ph8),
        .product_lo   (pl8)
    );

    shift_add_mul_ctrl #(.WIDTH(64)) dut64 (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (s64),
        .multiplicand (a64),
        .multiplier   (m64),
        .busy         (b64),
        .done         (d64),
        .product_hi   (ph64),
        .product_lo   (pl64)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // lat counts edges from the accepting edge (inclusive) to the edge after
    // which done is seen; -1 on timeout.
    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] hi, output logic [7:0] lo,
                        output int lat, output int bcnt);
        a8 = a; m8 = b; s8 = 1'b1;
        tick();
        s8 = 1'b0;
        lat = 1; bcnt = 0;
        while (!d8 && lat < 40) begin
            if (b8) bcnt++;
            tick();
            lat++;
        end
        if (!d8) lat = -1;
        hi = ph8; lo = pl8;
    endtask

    task automatic run64(input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] hi, output logic [63:0] lo,
                         output int lat);
        a64 = a; m64 = b; s64 = 1'b1;
        tick();
        s64 = 1'b0;
        lat = 1;
        while (!d64 && lat < 100) begin
            tick();
            lat++;
        end
        if (!d64) lat = -1;
        hi = ph64; lo = pl64;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        s8 = 0; a8 = 0; m8 = 0; s64 = 0; a64 = 0; m64 = 0;
        tick(); tick();
        checks++;
        if ({b8, d8, ph8, pl8} !== 18'd0) begin
            errors++;
            $display("FAIL reset8 got busy=%b done=%b hi=%h lo=%h want all 0", b8, d8, ph8, pl8);
        end
        checks++;
        if ({b64, d64, ph64, pl64} !== 130'd0) begin
            errors++;
            $display("FAIL reset64 got busy=%b done=%b hi=%h lo=%h want all 0", b64, d64, ph64, pl64);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] hi, lo;
        int lat, bcnt, seen_done;
        a8 = 8'd5; m8 = 8'd7; s8 = 1'b1;
        tick();
        s8 = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (b8 !== 1'b1) begin
            errors++;
            $display("FAIL midrun_busy got %b want 1", b8);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({b8, d8, ph8, pl8} !== 18'd0) begin
            errors++;
            $display("FAIL midrun_async got busy=%b done=%b hi=%h lo=%h want all 0", b8, d8, ph8, pl8);
        end
        tick();
        reset_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (d8 || b8) seen_done = 1;
            tick();
        end
        checks++;
        if (seen_done != 0) begin
            errors++;
            $display("FAIL midrun_no_done got activity=%0d want 0", seen_done);
        end
        run8(8'd5, 8'd7, hi, lo, lat, bcnt);
        checks++;
        if ({hi, lo} !== 16'd35 || lat != 9) begin
            errors++;
            $display("FAIL midrun_restart got prod=%0d lat=%0d want 35 lat 9", {hi, lo}, lat);
        end
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] hi, lo;
        int lat, bcnt;
        run8(8'd13, 8'd11, hi, lo, lat, bcnt);
        checks++;
        if (hi !== 8'h00 || lo !== 8'h8F) begin
            errors++;
            $display("FAIL basic_prod got hi=%h lo=%h want 00 8f", hi, lo);
        end
        checks++;
        if (lat != 9) begin
            errors++;
            $display("FAIL basic_latency got %0d want 9", lat);
        end
        checks++;
        if (bcnt != 8) begin
            errors++;
            $display("FAIL basic_busy_cycles got %0d want 8", bcnt);
        end
        tick();
        checks++;
        if (d8 !== 1'b0 || b8 !== 1'b0 || {ph8, pl8} !== 16'h008F) begin
            errors++;
            $display("FAIL basic_after got done=%b busy=%b prod=%h want 0 0 008f", d8, b8, {ph8, pl8});
        end
    endtask

    task automatic test_carry();
        logic [7:0] hi, lo;
        int lat, bcnt;
        run8(8'hFF, 8'hFF, hi, lo, lat, bcnt);
        checks++;
        if (hi !== 8'hFE || lo !== 8'h01 || lat != 9) begin
            errors++;
            $display("FAIL carry got hi=%h lo=%h lat=%0d want fe 01 lat 9", hi, lo, lat);
        end
        tick();
    endtask

    task automatic test_zero_one();
        logic [63:0] hi, lo;
        int lat;
        run64(64'd0, 64'hFFFF_FFFF_FFFF_FFFF, hi, lo, lat);
        checks++;
        if (hi !== 64'd0 || lo !== 64'd0 || lat != 65) begin
            errors++;
            $display("FAIL zero got hi=%h lo=%h lat=%0d want 0 0 lat 65", hi, lo, lat);
        end
        tick();
        run64(64'd1, 64'hDEAD_BEEF_0000_0001, hi, lo, lat);
        checks++;
        if (hi !== 64'd0 || lo !== 64'hDEAD_BEEF_0000_0001 || lat != 65) begin
            errors++;
            $display("FAIL one got hi=%h lo=%h lat=%0d want 0 deadbeef00000001 lat 65", hi, lo, lat);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        // First multiply 5*9 = 45; a stray start mid-run must be ignored.
        a8 = 8'd5; m8 = 8'd9; s8 = 1'b1;
        tick();
        s8 = 1'b0;
        n = 1;
        tick(); n++;
        a8 = 8'd200; m8 = 8'd200; s8 = 1'b1;
        tick(); n++;
        s8 = 1'b0;
        while (n < 8) begin
            tick(); n++;
        end
        // Last RUN cycle: raise start with the second operands and hold it.
        checks++;
        if (b8 !== 1'b1 || d8 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_still_run got busy=%b done=%b want 1 0", b8, d8);
        end
        a8 = 8'd3; m8 = 8'd4; s8 = 1'b1;
        tick();
        checks++;
        if (d8 !== 1'b1 || {ph8, pl8} !== 16'd45) begin
            errors++;
            $display("FAIL b2b_first got done=%b prod=%0d want 1 45", d8, {ph8, pl8});
        end
        tick();
        s8 = 1'b0;
        checks++;
        if (b8 !== 1'b1 || d8 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_idle got busy=%b done=%b want 1 0", b8, d8);
        end
        n = 1;
        while (!d8 && n < 40) begin
            tick(); n++;
        end
        checks++;
        if (d8 !== 1'b1 || n != 9 || {ph8, pl8} !== 16'd12) begin
            errors++;
            $display("FAIL b2b_second got done=%b lat=%0d prod=%0d want 1 9 12", d8, n, {ph8, pl8});
        end
        tick();
    endtask

    task automatic test_random();
        logic [63:0]  a, b, hi, lo;
        logic [127:0] ref_p;
        int lat;
        for (int i = 0; i < 1000; i++) begin
            a = {$urandom(), $urandom()};
            b = {$urandom(), $urandom()};
            ref_p = {64'd0, a} * {64'd0, b};
            run64(a, b, hi, lo, lat);
            checks++;
            if ({hi, lo} !== ref_p || lat != 65) begin
                errors++;
                $display("FAIL random[%0d] a=%h b=%h got %h lat=%0d want %h lat 65",
                         i, a, b, {hi, lo}, lat, ref_p);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_reset_mid_run();
        test_basic();
        test_carry();
        test_zero_one();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
